alu_issue_ctrl: RTL and testbench

Sequential issue controller that sits on the driving side of the datapath ALU, upstream of its `control_in`, `a` and `b` inputs. It accepts a decoded-instruction request over a valid/ready handshake and translates {ALUOp, funct3, funct7[5]} into the ALU's 4-bit control code. It drives the registered operands for one settle cycle, then captures `alu_result`/`zero` back from the ALU. It returns the result, the branch decision and an illegal-op flag over a second valid/ready handshake.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_ctrl_decode.sv | 48 ++++
 rtl/alu_issue_ctrl.sv | 115 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings, funct3 values and issue FSM states.
// Used by alu_ctrl_decode and alu_issue_ctrl.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [1:0] OP_MEM = 2'b00;
  localparam logic [1:0] OP_BR  = 2'b01;
  localparam logic [1:0] OP_R   = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_DONE  = 2'd2;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational {alu_op, funct3, funct7b5} to ALU control decoder.
// Shared with the single-cycle control path.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] ctrl,
  output logic       illegal,
  output logic       is_beq,
  output logic       is_bne
);

  always_comb begin
    ctrl    = ALU_NOP;
    illegal = 1'b1;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    unique case (1'b1)
      alu_op == OP_MEM: begin
        ctrl    = ALU_ADD;
        illegal = 1'b0;
      end
      alu_op == OP_BR: begin
        // unknown branch funct3 still subtracts, but never takes
        ctrl    = ALU_SUB;
        is_beq  = funct3 == F3_BEQ;
        is_bne  = funct3 == F3_BNE;
        illegal = !(is_beq || is_bne);
      end
      alu_op == OP_R && funct3 == F3_ADD: begin
        ctrl    = funct7b5 ? ALU_SUB : ALU_ADD;
        illegal = 1'b0;
      end
      alu_op == OP_R && funct3 == F3_AND: begin
        ctrl    = ALU_AND;
        illegal = 1'b0;
      end
      alu_op == OP_R && funct3 == F3_OR: begin
        ctrl    = ALU_OR;
        illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller driving the datapath ALU; two-edge request/response.
// Optional ALU_ISSUE_PERF_EN adds perf_ops / perf_illegal counters.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_alu_op,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [WIDTH-1:0] in_op_a,
  input  logic [WIDTH-1:0] in_op_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_taken,
  output logic             out_illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_illegal
`endif
);

  state_t     state;
  logic [3:0] dec_ctrl;
  logic       dec_ill;
  logic       dec_beq;
  logic       dec_bne;
  logic       ill_q;
  logic       beq_q;
  logic       bne_q;
  logic       accept;

  alu_ctrl_decode u_dec (
    .alu_op   (in_alu_op),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .ctrl     (dec_ctrl),
    .illegal  (dec_ill),
    .is_beq   (dec_beq),
    .is_bne   (dec_bne)
  );

  assign in_ready = (state == S_IDLE) ||
                    (state == S_DONE && out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= ALU_AND;
      ill_q       <= 1'b0;
      beq_q       <= 1'b0;
      bne_q       <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_taken   <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      if (accept) begin
        alu_a    <= in_op_a;
        alu_b    <= in_op_b;
        alu_ctrl <= dec_ctrl;
        ill_q    <= dec_ill;
        beq_q    <= dec_beq;
        bne_q    <= dec_bne;
      end
      case (state)
        S_IDLE: begin
          if (accept) state <= S_ISSUE;
        end
        S_ISSUE: begin
          out_result  <= alu_result;
          out_taken   <= (beq_q && alu_zero) ||
                         (bne_q && !alu_zero);
          out_illegal <= ill_q;
          out_valid   <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= accept ? S_ISSUE : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops     <= '0;
      perf_illegal <= '0;
    end else if (out_valid && out_ready) begin
      perf_ops <= perf_ops + 32'd1;
      if (out_illegal) perf_illegal <= perf_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl against a transaction-level model.
// Define ALU_ISSUE_PERF_EN to also check the perf counters.
module tb_alu_issue_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, in_ready;
  logic [1:0]   in_alu_op;
  logic [2:0]   in_funct3;
  logic         in_funct7b5;
  logic [W-1:0] in_op_a, in_op_b;
  logic [W-1:0] alu_a, alu_b, alu_result, out_result;
  logic [3:0]   alu_ctrl;
  logic         alu_zero;
  logic         out_valid, out_ready, out_taken, out_illegal;
  logic [31:0]  perf_ops, perf_illegal;

  always #5 clk = ~clk;

`ifdef ALU_ISSUE_PERF_EN
  alu_issue_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_funct3(in_funct3),
    .in_funct7b5(in_funct7b5),
    .in_op_a(in_op_a), .in_op_b(in_op_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_taken(out_taken),
    .out_illegal(out_illegal),
    .perf_ops(perf_ops), .perf_illegal(perf_illegal)
  );
`else
  alu_issue_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_funct3(in_funct3),
    .in_funct7b5(in_funct7b5),
    .in_op_a(in_op_a), .in_op_b(in_op_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_taken(out_taken),
    .out_illegal(out_illegal)
  );
  assign perf_ops = '0;
  assign perf_illegal = '0;
`endif

  // datapath ALU the controller drives
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = alu_result == '0;

  typedef struct {
    logic [1:0]   op;
    logic [2:0]   f3;
    logic         f7;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } req_t;

  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] res;
    logic         taken;
    logic         ill;
    logic         chk_res;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic exp_t ref_model(input req_t r);
    exp_t e;
    e.a = r.a;
    e.b = r.b;
    e.taken = 1'b0;
    e.ill = 1'b0;
    e.chk_res = 1'b1;
    e.ctrl = 4'hF;
    e.res = '0;
    if (r.op == 2'd0) begin
      e.ctrl = 4'h2; e.res = r.a + r.b;
    end else if (r.op == 2'd1) begin
      e.ctrl = 4'h6; e.res = r.a - r.b;
      if (r.f3 == 3'd0) e.taken = (r.a == r.b);
      else if (r.f3 == 3'd1) e.taken = (r.a != r.b);
      else begin
        e.ill = 1'b1; e.chk_res = 1'b0;
      end
    end else if (r.op == 2'd2 && r.f3 == 3'd0) begin
      e.ctrl = r.f7 ? 4'h6 : 4'h2;
      e.res = r.f7 ? r.a - r.b : r.a + r.b;
    end else if (r.op == 2'd2 && r.f3 == 3'd7) begin
      e.ctrl = 4'h0; e.res = r.a & r.b;
    end else if (r.op == 2'd2 && r.f3 == 3'd6) begin
      e.ctrl = 4'h1; e.res = r.a | r.b;
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic req_t next_req(input int n);
    req_t r;
    r.op = 2'($urandom_range(3));
    r.f3 = 3'($urandom_range(7));
    r.f7 = 1'($urandom_range(1));
    r.a = $urandom;
    r.b = ($urandom_range(3) == 0) ? r.a : $urandom;
    case (n)
      0: r = '{2'd2, 3'd0, 1'b0, 32'd5, 32'd7};
      1: r = '{2'd2, 3'd0, 1'b1, 32'd0, 32'd1};
      2: r = '{2'd1, 3'd0, 1'b0, 32'h1234, 32'h1234};
      3: r = '{2'd1, 3'd1, 1'b0, 32'h1234, 32'h1234};
      4: r = '{2'd1, 3'd1, 1'b0, 32'd1, 32'd2};
      5: r = '{2'd2, 3'd1, 1'b0, 32'h55, 32'h0F};
      default: ;
    endcase
    return r;
  endfunction

  task automatic drive(input req_t r);
    in_alu_op   = r.op;
    in_funct3   = r.f3;
    in_funct7b5 = r.f7;
    in_op_a     = r.a;
    in_op_b     = r.b;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_ctrl"}, 32'(alu_ctrl), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_result"}, out_result, 0);
    check({tag, "_out_taken"}, 32'(out_taken), 0);
    check({tag, "_out_illegal"}, 32'(out_illegal), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
`ifdef ALU_ISSUE_PERF_EN
    check({tag, "_perf_ops"}, perf_ops, 0);
    check({tag, "_perf_ill"}, perf_illegal, 0);
`endif
  endtask

  req_t cur;
  exp_t e;
  logic have, inflight, m_ready, exp_ov;
  int age, nreq;
  int m_ops, m_ill;

  initial begin
    in_valid = 1'b0;
    out_ready = 1'b1;
    cur = next_req(99);
    drive(cur);
    repeat (2) @(negedge clk);
    #1 check_reset_outs("reset");
    @(negedge clk) rst_n = 1'b1;

    have = 1'b0; inflight = 1'b0;
    age = 0; nreq = 0; m_ops = 0; m_ill = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (!have && (cyc < 30 || $urandom_range(3) != 0)) begin
        cur = next_req(nreq);
        have = 1'b1;
      end
      in_valid = have;
      if (have) drive(cur);
      else drive(next_req(99));
      if (cyc >= 20 && cyc < 26) out_ready = 1'b0;
      else if (cyc < 30) out_ready = 1'b1;
      else out_ready = ($urandom_range(4) != 0);
      #1;
      exp_ov  = inflight && age >= 1;
      m_ready = !inflight || (exp_ov && out_ready);
      check("in_ready", 32'(in_ready), 32'(m_ready));
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
        if (e.chk_res) check("out_result", out_result, e.res);
        check("out_taken", 32'(out_taken), 32'(e.taken));
        check("out_illegal", 32'(out_illegal), 32'(e.ill));
      end
      if (inflight && age == 0) begin
        check("alu_ctrl", 32'(alu_ctrl), 32'(e.ctrl));
        check("alu_a", alu_a, e.a);
        check("alu_b", alu_b, e.b);
      end
`ifdef ALU_ISSUE_PERF_EN
      check("perf_ops", perf_ops, m_ops);
      check("perf_illegal", perf_illegal, m_ill);
`endif
      @(posedge clk);
      if (exp_ov && out_ready) begin
        inflight = 1'b0;
        m_ops++;
        if (e.ill) m_ill++;
      end
      if (inflight) age++;
      if (in_valid && m_ready) begin
        e = ref_model(cur);
        inflight = 1'b1;
        age = 0;
        have = 1'b0;
        nreq++;
      end
    end

    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("drain_idle", 32'(in_ready), 1);

    // reset while the op sits in ISSUE
    cur = '{2'd0, 3'd0, 1'b0, 32'd9, 32'd4};
    drive(cur);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("rst_issue_ctrl", 32'(alu_ctrl), 32'h2);
    check("rst_issue_busy", 32'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("rst_mid");
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_ov", 32'(out_valid), 0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_after_ov", 32'(out_valid), 0);
      check("rst_after_rdy", 32'(in_ready), 1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
